// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - button, counter-status and preset/status bundle for countdown_timer_ctrl
interface countdown_timer_if;
    logic       pb_start_stop;
    logic       pb_reset;
    logic       pb_sel;
    logic       pb_inc;
    logic       cnt_zero;
    logic       cnt_en;
    logic       cnt_load;
    logic [3:0] init_2;
    logic [3:0] init_1;
    logic [3:0] init_0;
    logic [1:0] sel;
    logic [1:0] state;
    logic       alarm;

    modport master (
        output pb_start_stop, pb_reset, pb_sel, pb_inc, cnt_zero,
        input  cnt_en, cnt_load, init_2, init_1, init_0, sel, state, alarm
    );

    modport slave (
        input  pb_start_stop, pb_reset, pb_sel, pb_inc, cnt_zero,
        output cnt_en, cnt_load, init_2, init_1, init_0, sel, state, alarm
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - SET/RUN/PAUSE/DONE sequencer, preset registers and tick prescaler for the BCD down counter
// Optional ALARM_BLINK_EN: alarm blinks in DONE with period 2*TICK_DIV instead of holding steady.
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    countdown_timer_if.slave    bus
);
    localparam logic [1:0] ST_SET   = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       init_2_q, init_2_d;
    logic [3:0]       init_1_q, init_1_d;
    logic [3:0]       init_0_q, init_0_d;
    logic [1:0]       sel_q, sel_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_load_q, cnt_load_d;
    logic             alarm_q, alarm_d;
    logic             preset_zero;
    logic             presc_wrap;
    logic [CNT_W-1:0] presc_next;

    always_comb begin
        preset_zero = (init_2_q == 4'd0) && (init_1_q == 4'd0) && (init_0_q == 4'd0);
        presc_wrap  = (presc_q == PRESC_LAST);
        presc_next  = presc_wrap ? '0 : presc_q + CNT_W'(1);

        // Priority: pb_reset > cnt_zero > pb_start_stop
        state_d = state_q;
        case (state_q)
            ST_SET: begin
                if (bus.pb_start_stop && !bus.pb_reset && !preset_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.pb_reset)           state_d = ST_SET;
                else if (bus.cnt_zero)      state_d = ST_DONE;
                else if (bus.pb_start_stop) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.pb_reset)           state_d = ST_SET;
                else if (bus.pb_start_stop) state_d = ST_RUN;
            end
            default: begin
                if (bus.pb_reset || bus.pb_start_stop) state_d = ST_SET;
            end
        endcase

        // Prescaler only advances on cycles that stay in RUN, so the exit cycle does not count
        presc_d = presc_q;
        if (state_d == ST_SET) begin
            presc_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            presc_d = presc_next;
        end else if (state_d == ST_DONE) begin
`ifdef ALARM_BLINK_EN
            presc_d = (state_q == ST_DONE) ? presc_next : '0;
`else
            presc_d = '0;
`endif
        end

        cnt_en_d   = (state_q == ST_RUN) && (state_d == ST_RUN) && presc_wrap;
        cnt_load_d = (state_d == ST_SET);

`ifdef ALARM_BLINK_EN
        if (state_d != ST_DONE)      alarm_d = 1'b0;
        else if (state_q != ST_DONE) alarm_d = 1'b1;
        else if (presc_wrap)         alarm_d = ~alarm_q;
        else                         alarm_d = alarm_q;
`else
        alarm_d = (state_d == ST_DONE);
`endif

        init_2_d = init_2_q;
        init_1_d = init_1_q;
        init_0_d = init_0_q;
        sel_d    = sel_q;
        if (state_q == ST_SET) begin
            // Increment uses the old sel even when pb_sel arrives in the same cycle
            if (bus.pb_inc) begin
                case (sel_q)
                    2'd0:    init_0_d = (init_0_q == 4'd9) ? 4'd0 : init_0_q + 4'd1;
                    2'd1:    init_1_d = (init_1_q == 4'd5) ? 4'd0 : init_1_q + 4'd1;
                    default: init_2_d = (init_2_q == 4'd9) ? 4'd0 : init_2_q + 4'd1;
                endcase
            end
            if (bus.pb_sel) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_SET;
            presc_q    <= '0;
            init_2_q   <= 4'd1;
            init_1_q   <= 4'd0;
            init_0_q   <= 4'd0;
            sel_q      <= 2'd0;
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b1;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            init_2_q   <= init_2_d;
            init_1_q   <= init_1_d;
            init_0_q   <= init_0_d;
            sel_q      <= sel_d;
            cnt_en_q   <= cnt_en_d;
            cnt_load_q <= cnt_load_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.cnt_en   = cnt_en_q;
    assign bus.cnt_load = cnt_load_q;
    assign bus.init_2   = init_2_q;
    assign bus.init_1   = init_1_q;
    assign bus.init_0   = init_0_q;
    assign bus.sel      = sel_q;
    assign bus.state    = state_q;
    assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - scoreboard bench for countdown_timer_ctrl at TICK_DIV=4
module tb_countdown_timer_ctrl;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 4;

    localparam int K_STATE = 0;
    localparam int K_PRESET = 1;
    localparam int K_SEL = 2;
    localparam int K_LOAD = 3;
    localparam int K_EN = 4;
    localparam int K_ALARM = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   en_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dut_val(int kind);
        case (kind)
            K_STATE:  return int'(bus.state);
            K_PRESET: return int'({bus.init_2, bus.init_1, bus.init_0});
            K_SEL:    return int'(bus.sel);
            K_LOAD:   return int'(bus.cnt_load);
            K_EN:     return int'(bus.cnt_en);
            default:  return int'(bus.alarm);
        endcase
    endfunction

    // Monitor: drains expectations due this cycle and tracks every cnt_en pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        int   got;
        int   due;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            got = dut_val(e.kind);
            n_cmp++;
            if (e.cyc != cyc || got != e.val) begin
                n_bad++;
                $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d, due %0d)", e.name, got, e.val, cyc, e.cyc);
            end
        end
        if (bus.cnt_en) begin
            n_cmp++;
            if (en_q.size() == 0) begin
                n_bad++;
                $display("FAIL cnt_en_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                due = en_q.pop_front();
                if (due != cyc) begin
                    n_bad++;
                    $display("FAIL cnt_en_timing: got pulse at cycle %0d expected cycle %0d", cyc, due);
                end
            end
        end else if (en_q.size() > 0 && en_q[0] <= cyc) begin
            due = en_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL cnt_en_missing: got 0 at cycle %0d expected pulse at cycle %0d", cyc, due);
        end
    end

    task automatic chk(int kind, int val, string name);
        exp_t e;
        e.cyc = cyc;
        e.kind = kind;
        e.val = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic chk_all(int st, int preset, int sl, int ld, int en, int al, string name);
        chk(K_STATE, st, {name, ".state"});
        chk(K_PRESET, preset, {name, ".preset"});
        chk(K_SEL, sl, {name, ".sel"});
        chk(K_LOAD, ld, {name, ".cnt_load"});
        chk(K_EN, en, {name, ".cnt_en"});
        chk(K_ALARM, al, {name, ".alarm"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_n(int n);
        repeat (n) begin
            bus.pb_inc = 1'b1;
            tick();
            bus.pb_inc = 1'b0;
        end
    endtask

    task automatic sel_n(int n);
        repeat (n) begin
            bus.pb_sel = 1'b1;
            tick();
            bus.pb_sel = 1'b0;
        end
    endtask

    task automatic press_ss();
        bus.pb_start_stop = 1'b1;
        tick();
        bus.pb_start_stop = 1'b0;
    endtask

    function automatic int blink_exp(int i);
`ifdef ALARM_BLINK_EN
        return ((i / 4) % 2 == 0) ? 1 : 0;
`else
        return (i >= 0) ? 1 : 0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int r0;
        bus.pb_start_stop = 1'b0;
        bus.pb_reset = 1'b0;
        bus.pb_sel = 1'b0;
        bus.pb_inc = 1'b0;
        bus.cnt_zero = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_all(0, 'h100, 0, 1, 0, 0, "reset");

        inc_n(12);
        chk(K_PRESET, 'h102, "inc12_init0");
        sel_n(1);
        chk(K_SEL, 1, "sel_to_1");
        inc_n(7);
        chk(K_PRESET, 'h112, "inc7_init1_wrap");
        sel_n(2);
        chk(K_SEL, 0, "sel_wrap_to_0");

        sel_n(2);
        bus.pb_inc = 1'b1;
        bus.pb_sel = 1'b1;
        tick();
        bus.pb_inc = 1'b0;
        bus.pb_sel = 1'b0;
        chk(K_PRESET, 'h212, "inc_sel_together_preset");
        chk(K_SEL, 0, "inc_sel_together_sel");

        // Clear preset to 0:00 digit by digit
        sel_n(2);
        inc_n(8);
        sel_n(2);
        inc_n(5);
        sel_n(2);
        inc_n(8);
        chk_all(0, 'h000, 0, 1, 0, 0, "preset_zero");
        press_ss();
        chk(K_STATE, 0, "zero_start_ignored");
        chk(K_LOAD, 1, "zero_start_load");

        inc_n(3);
        press_ss();
        c0 = cyc;
        en_q.push_back(c0 + 4);
        en_q.push_back(c0 + 8);
        en_q.push_back(c0 + 12);
        chk_all(1, 'h003, 0, 0, 0, 0, "run_entry");
        repeat (12) tick();
        chk(K_EN, 1, "third_tick");
        bus.cnt_zero = 1'b1;
        tick();
        bus.cnt_zero = 1'b0;
        chk_all(3, 'h003, 0, 0, 0, 1, "done_entry");
        for (int i = 0; i < 12; i++) begin
            chk(K_ALARM, blink_exp(i), "done_alarm");
            chk(K_STATE, 3, "done_hold");
            tick();
        end
        press_ss();
        chk_all(0, 'h003, 0, 1, 0, 0, "done_ack");

        press_ss();
        chk(K_STATE, 1, "run_again");
        tick();
        tick();
        press_ss();
        chk_all(2, 'h003, 0, 0, 0, 0, "pause_entry");
        repeat (10) tick();
        chk(K_STATE, 2, "pause_hold");
        press_ss();
        r0 = cyc;
        en_q.push_back(r0 + 2);
        chk(K_STATE, 1, "resume");
        tick();
        tick();
        chk(K_EN, 1, "resume_tick");

        bus.pb_reset = 1'b1;
        bus.pb_start_stop = 1'b1;
        tick();
        bus.pb_reset = 1'b0;
        bus.pb_start_stop = 1'b0;
        chk_all(0, 'h003, 0, 1, 0, 0, "reset_beats_ss");

        press_ss();
        chk(K_STATE, 1, "run_before_rst");
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all(0, 'h100, 0, 1, 0, 0, "sync_reset_mid_run");

        press_ss();
        chk(K_LOAD, 0, "run_load_low");
        inc_n(1);
        sel_n(1);
        chk(K_PRESET, 'h100, "run_inc_ignored");
        chk(K_SEL, 0, "run_sel_ignored");
        bus.pb_reset = 1'b1;
        tick();
        bus.pb_reset = 1'b0;
        chk_all(0, 'h100, 0, 1, 0, 0, "abort_to_set");

        tick();
        @(negedge clk);
        #1;
        n_cmp++;
        if (en_q.size() != 0) begin
            n_bad++;
            $display("FAIL cnt_en_pending: got %0d outstanding expected 0", en_q.size());
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL exp_pending: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
